// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default parameters and the carry recovery helper.
package shift_add_mult_ctrl_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // The shared adder has no carry-out, so rebuild it from the operand and sum MSBs.
  function automatic logic derive_carry(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// 32-bit ripple-carry adder, purely combinational, carry-out discarded.
// Settling time is covered by the controller's settle counter.
module adder32x32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic [31:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < 31) begin : g_c
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 32x32 unsigned multiplier: one add/shift step per iteration, each
// add given SETTLE_CYCLES clocks for the shared ripple adder to settle.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] ITER_LAST   = 5'd31;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic [4:0]           iter_q, iter_d;
  logic [3:0]           settle_q, settle_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   shifted;

  // Adder sees registers only, so its output is stable for the whole ADD window.
  assign addend = acc_lo_q[0] ? mcand_q : '0;

  adder32x32 u_adder (
    .a   (acc_hi_q),
    .b   (addend),
    .sum (sum)
  );

  assign carry   = derive_carry(acc_hi_q[WIDTH-1], addend[WIDTH-1], sum[WIDTH-1]);
  assign shifted = {carry, sum, acc_lo_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    iter_d    = iter_q;
    settle_d  = settle_q;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = multiplicand;
          acc_hi_d = '0;
          acc_lo_d = multiplier;
          iter_d   = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        settle_d = '0;
        state_d  = ST_ADD;
      end
      ST_ADD: begin
        if (settle_q == SETTLE_LAST) state_d = ST_SHIFT;
        else                         settle_d = settle_q + 4'd1;
      end
      ST_SHIFT: begin
        {acc_hi_d, acc_lo_d} = shifted;
        iter_d = iter_q + 5'd1;
        if (iter_q == ITER_LAST) begin
          // Latch the result here so it survives the next accept overwriting acc_lo.
          product_d = shifted;
          state_d   = ST_DONE;
        end else begin
          settle_d = '0;
          state_d  = ST_ADD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      iter_q    <= '0;
      settle_q  <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      iter_q    <= iter_d;
      settle_q  <= settle_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: doc/shift_add_mult_ctrl.md
SHIFT_ADD_MULT_CTRL -- requirements
Module: shift_add_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 Parameter: SETTLE_CYCLES, 2, clock cycles the ripple adder is given to settle per iteration; legal range 1..15.
REQ-003 Clock: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  request to multiply; accepted only in IDLE.
REQ-007 Port: multiplicand  input  32  unsigned operand A; sampled on the accept edge.
REQ-008 Port: multiplier  input  32  unsigned operand B; sampled on the accept edge.
REQ-009 Port: busy  output  1  high in every state other than IDLE.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: product  output  64  unsigned A*B; valid from done until the next accept edge.

Function
REQ-012 FSM states: IDLE, LOAD, ADD, SHIFT, DONE.
REQ-013 IDLE with start=1 on an edge: capture A into mcand_r; set acc_hi=0 and acc_lo=B; clear iter_cnt; go to LOAD.
REQ-014 LOAD: go to ADD after 1 cycle; zero the settle counter.
REQ-015 Adder inputs: acc_hi, and (acc_lo[0] ? mcand_r : 0); the adder is driven combinationally from registers only.
REQ-016 ADD: hold for exactly SETTLE_CYCLES cycles, counted by the settle counter, then go to SHIFT; registers are unchanged while in ADD.
REQ-017 SHIFT, one cycle: derive carry = (a31 & b31) | ((a31 | b31) & ~s31), because the shared adder has no carry-out.
REQ-018 SHIFT: {acc_hi, acc_lo} <= {carry, sum, acc_lo[31:1]}; then increment iter_cnt.
REQ-019 SHIFT with iter_cnt = 31 before the increment goes to DONE; otherwise it goes to ADD with the settle counter zeroed.
REQ-020 Every operand, including zero, runs all 32 iterations; there is no early termination.
REQ-021 Latency: done rises after edge 1+32*(SETTLE_CYCLES+1) counted from the accept edge (97 for SETTLE_CYCLES=2; 65 for SETTLE_CYCLES=1).
REQ-022 DONE: done=1 for exactly one cycle; product={acc_hi, acc_lo}; the next edge goes to IDLE.
REQ-023 product is held unchanged in IDLE until the next accept; the result never overflows 64 bits.
REQ-024 start while busy=1, including during the DONE cycle, is ignored and not queued.
REQ-025 start asserted in the IDLE cycle directly after DONE is accepted normally, giving back-to-back operation.
REQ-026 A change to multiplicand or multiplier after the accept edge has no effect on the result.

Reset
REQ-027 rst_n=0 forces, asynchronously: state=IDLE, busy=0, done=0, product=0, acc_hi=0, acc_lo=0, mcand_r=0, iter_cnt=0, settle counter=0.
REQ-028 Reset asserted during an operation aborts it without producing a done pulse; the first edge after reset release may accept start.

Structure
REQ-029 A shared package holds the FSM state encoding (3 bits), the WIDTH default and the SETTLE_CYCLES default.
REQ-030 The design contains one sub-module: the team's 32-bit ripple adder adder32x32, instantiated once, combinational, with no carry-out.
REQ-031 The FSM, counters and accumulator registers are implemented in this module; they do not appear in a separate sub-module.

Verification
REQ-032 Case: SETTLE_CYCLES=1, A=3, B=5, start pulsed -> done high 65 cycles after the accept edge; product=0x000000000000000F.
REQ-033 Case: A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0xFFFFFFFE00000001, which exercises the derived carry.
REQ-034 Case: A=0x00001234, B=0 -> product=0 after the full latency; done is a single-cycle pulse.
REQ-035 Case: start re-pulsed with A=7, B=7 at cycle 10 of an operation with A=2, B=9 -> product=18; no second done occurs.
REQ-036 Case: rst_n low at cycle 40 of an operation -> busy=0, done=0, product=0 immediately; a following start with A=6, B=7 gives 42.
REQ-037 Case: start held high continuously -> operations repeat back to back with done pulses 1+32*(SETTLE_CYCLES+1)+2 cycles apart.
